fix2fp: RTL
===========

FIX2FP -- requirements
Module: fix2fp

Interface
REQ-001 Parameter I_EXP, default 8, SHALL set output exponent width.
REQ-002 Parameter I_MNT, default 23, SHALL set output stored-mantissa width.
REQ-003 Parameter FX_W, default 16, SHALL set input fixed-point width (two's complement).
REQ-004 Parameter FX_FRAC, default 15, SHALL set input fractional bits (default Q1.15).
REQ-005 clk  input  1  SHALL be the clock; all state changes on rising edge.
REQ-006 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-007 enable  input  1  SHALL be the pipeline advance: high = advance, low = hold all stages.
REQ-008 in_valid  input  1  SHALL qualify idata on a cycle where enable=1.
REQ-009 idata  input  FX_W  SHALL be the signed fixed-point sample.
REQ-010 odata  output  I_EXP+I_MNT+1  SHALL be the float result {sign, exp, mantissa}, bias 2^(I_EXP-1)-1.
REQ-011 out_valid  output  1  SHALL mark odata as a valid result.

Function
REQ-012 Pipeline SHALL be 3 stages; sample accepted at edge N appears on odata/out_valid after edge N+2 (3 enabled cycles).
REQ-013 Stage 1 SHALL register sign = idata MSB, magnitude = |idata| in FX_W bits, and a zero flag (idata==0).
REQ-014 Magnitude of the most negative input (-2^(FX_W-1)) SHALL be represented exactly as 2^(FX_W-1), not saturated.
REQ-015 Stage 2 SHALL find leading-one position p of magnitude and left-shift magnitude so bit p lands at the hidden-bit position.
REQ-016 Stage 2 SHALL compute exp = bias + p - FX_FRAC in I_EXP bits.
REQ-017 Stage 3 SHALL pack {sign, exp, shifted magnitude below hidden bit, zero-padded to I_MNT}.
REQ-018 When magnitude has more than I_MNT+1 significant bits, mantissa SHALL round to nearest-even; carry-out SHALL increment exp and clear mantissa.
REQ-019 Zero input SHALL produce odata all-zero (sign 0, exp 0, mantissa 0), matching the pipeline's exp==0 zero convention.
REQ-020 out_valid SHALL equal in_valid delayed through the 3 stages; bubbles (in_valid=0) SHALL propagate as out_valid=0.
REQ-021 While enable=0, every stage register, odata and out_valid SHALL hold their values; no sample accepted.
REQ-022 Denormal outputs SHALL not be generated; exponent range with defaults (112..127) never underflows.

Reset
REQ-023 reset=1 at a rising edge SHALL clear all stage registers; odata=0 and out_valid=0 the following cycle.
REQ-024 reset SHALL take priority over enable; samples in flight when reset asserts SHALL be discarded.
REQ-025 First sample accepted after reset deasserts SHALL obey REQ-012 latency with no residual data.

Structure
REQ-026 Shared package fp_pkg SHALL hold I_EXP/I_MNT defaults, exponent bias constant, and a packed fp32 struct {sign, exp, mnt}.
REQ-027 Leading-one detection SHALL reuse the existing lead_one sub-module (IDATA_BIT=FX_W, ODATA_BIT=$clog2(FX_W)+1); no other sub-module.
REQ-028 Output odata SHALL be directly consumable as an fp_add operand with no glue logic.

Verification
REQ-029 idata=0x4000, in_valid=1 -> 3 cycles later odata=0x3F000000 (0.5), out_valid=1.
REQ-030 idata=0x8000 -> odata=0xBF800000 (-1.0); idata=0x7FFF -> odata=0x3F7FFE00.
REQ-031 idata=0x0001 -> odata=0x38000000; idata=0x0000 -> odata=0x00000000, out_valid=1.
REQ-032 Stream 0x4000,0xC000,0x2000 with enable low for 2 cycles after 2nd sample -> outputs 0x3F000000,0xBF000000,0x3E800000 in order, odata/out_valid frozen during stall.
REQ-033 in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 after 3 cycles; reset asserted with 2 samples in flight -> out_valid=0, odata=0 next cycle, no stale output after release.
REQ-034 Randomised Q1.15 inputs -> odata bit-exact vs real-valued reference; fix2fp->fp_add(a,-a) yields 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default field widths, exponent bias and
// the packed single-precision layout used by fix2fp and its consumers.
package fp_pkg;

    localparam int FP_EXP  = 8;
    localparam int FP_MNT  = 23;
    localparam int FP_BIAS = (1 << (FP_EXP - 1)) - 1;

    typedef struct packed {
        logic              sign;
        logic [FP_EXP-1:0] exp;
        logic [FP_MNT-1:0] mnt;
    } fp32_t;

endpackage

// File: rtl/lead_one.sv
// Leading-one detector: reports the bit index of the most significant set bit
// (0 when the input is all-zero; callers track zero separately).
module lead_one #(
    parameter int IDATA_BIT = 16,
    parameter int ODATA_BIT = 5
) (
    input  logic [IDATA_BIT-1:0] idata,
    output logic [ODATA_BIT-1:0] odata
);

    always_comb begin
        odata = '0;
        for (int unsigned i = 0; i < IDATA_BIT; i++) begin
            if (idata[i]) odata = ODATA_BIT'(i);
        end
    end

endmodule

// File: rtl/fix2fp.sv
// Three-stage signed fixed-point to floating-point converter:
// sign/magnitude, normalise + exponent, then round/pack.
module fix2fp
    import fp_pkg::*;
#(
    parameter int I_EXP   = FP_EXP,
    parameter int I_MNT   = FP_MNT,
    parameter int FX_W    = 16,
    parameter int FX_FRAC = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_valid,
    input  logic [FX_W-1:0]        idata,
    output logic [I_EXP+I_MNT:0]   odata,
    output logic                   out_valid
);

    localparam int BIAS  = (1 << (I_EXP - 1)) - 1;
    localparam int POS_W = $clog2(FX_W) + 1;
    localparam int FB    = FX_W - 1;

    logic            s1_valid, s1_sign, s1_zero;
    logic [FX_W-1:0] s1_mag;

    logic             s2_valid, s2_sign, s2_zero;
    logic [I_EXP-1:0] s2_exp;
    logic [FB-1:0]    s2_frac;

    logic [FX_W-1:0]  mag_next;
    logic [POS_W-1:0] lead_pos;
    logic [POS_W-1:0] shift;
    logic [FB-1:0]    frac_next;
    logic [I_EXP-1:0] exp_next;
    logic [I_EXP-1:0] exp_pack;
    logic [I_MNT-1:0] mnt_pack;

    // Two's-complement negate in FX_W bits maps -2^(FX_W-1) onto itself, which
    // read unsigned is exactly 2^(FX_W-1).
    assign mag_next = idata[FX_W-1] ? (~idata + 1'b1) : idata;

    lead_one #(
        .IDATA_BIT(FX_W),
        .ODATA_BIT(POS_W)
    ) u_lead_one (
        .idata(s1_mag),
        .odata(lead_pos)
    );

    assign shift     = POS_W'(FB) - lead_pos;
    assign frac_next = FB'(s1_mag << shift);
    assign exp_next  = I_EXP'(BIAS + int'(lead_pos) - FX_FRAC);

    generate
        if (FB <= I_MNT) begin : g_pad
            always_comb begin
                mnt_pack = I_MNT'(s2_frac) << (I_MNT - FB);
                exp_pack = s2_exp;
            end
        end else begin : g_round
            localparam int D = FB - I_MNT;
            logic [I_MNT-1:0] kept;
            logic [D-1:0]     rem;
            logic [D-1:0]     half;
            logic             round_up;
            logic [I_MNT:0]   sum;
            // Round to nearest even; a carry out of the mantissa bumps the exponent.
            always_comb begin
                kept     = s2_frac[FB-1 -: I_MNT];
                rem      = s2_frac[D-1:0];
                half     = D'(1) << (D - 1);
                round_up = (rem > half) || ((rem == half) && kept[0]);
                sum      = {1'b0, kept} + (I_MNT+1)'(round_up);
                mnt_pack = sum[I_MNT-1:0];
                exp_pack = s2_exp + I_EXP'(sum[I_MNT]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_mag    <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
            s2_exp    <= '0;
            s2_frac   <= '0;
            odata     <= '0;
            out_valid <= 1'b0;
        end else if (enable) begin
            s1_valid  <= in_valid;
            s1_sign   <= idata[FX_W-1];
            s1_zero   <= (idata == '0);
            s1_mag    <= mag_next;
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_zero   <= s1_zero;
            s2_exp    <= exp_next;
            s2_frac   <= frac_next;
            odata     <= s2_zero ? '0 : {s2_sign, exp_pack, mnt_pack};
            out_valid <= s2_valid;
        end
    end

endmodule
